wavegen: RTL and testbench

Multi-channel, parametrised waveform generator. It is the successor to the single fixed-rate sawtooth/triangle counter. Each channel has its own phase accumulator with a programmable increment and a selectable waveform. New settings are taken through a valid/ready config port and applied glitch-free at the channel's next phase wrap. It sits between the control register block and the PWM/LED and DAC output stages.

---
 rtl/wavegen_pkg.sv | 22 ++
 rtl/wavegen_if.sv | 29 ++
 rtl/wavegen_ch.sv | 115 +++++++++++
 rtl/wavegen.sv | 49 ++++
 tb/tb_wavegen.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// Shared types for the multi-channel waveform generator.
package wavegen_pkg;

  localparam int MODE_W = 2;

  // Waveform selection as presented on the config port.
  typedef enum logic [MODE_W-1:0] {
    MODE_SAW_UP   = 2'd0,
    MODE_SAW_DOWN = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SQUARE   = 2'd3
  } mode_t;

  // Per-channel life cycle: idle, free-running, or running with a shadow
  // config waiting for the next phase wrap.
  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_PEND
  } state_t;

endpackage

// File: rtl/wavegen_if.sv
// Config/sample bus between the control register block and wavegen.
interface wavegen_if #(
  parameter int ACC_W = 27,
  parameter int OUT_W = 8,
  parameter int NCH   = 4,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) ();

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CH_W-1:0]        cfg_ch;
  logic                   cfg_en;
  logic [1:0]             cfg_mode;
  logic [ACC_W-1:0]       cfg_inc;
  logic                   sync;
  logic [NCH*OUT_W-1:0]   val;
  logic [NCH-1:0]         wrap;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_mode, cfg_inc, sync,
    input  cfg_ready, val, wrap
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_mode, cfg_inc, sync,
    output cfg_ready, val, wrap
  );

endinterface

// File: rtl/wavegen_ch.sv
// One waveform channel: phase accumulator, shadow config, FSM and shaper.
module wavegen_ch
  import wavegen_pkg::*;
#(
  parameter int ACC_W = 27,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             sync,
  input  logic             en,
  input  mode_t            mode,
  input  logic [ACC_W-1:0] inc,
  output logic             pend,
  output logic             wrap,
  output logic [OUT_W-1:0] val
);

  typedef struct packed {
    logic             en;
    mode_t            mode;
    logic [ACC_W-1:0] inc;
  } cfg_t;

  state_t           state_q;
  cfg_t             act_q;
  cfg_t             shadow_q;
  cfg_t             wr_cfg;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   step;

  assign wr_cfg = '{en: en, mode: mode, inc: inc};
  assign step   = {1'b0, acc_q} + {1'b0, act_q.inc};
  assign pend   = (state_q == ST_PEND);

  function automatic logic [OUT_W-1:0] shape(mode_t sel, logic [ACC_W-1:0] p);
    logic [OUT_W-1:0] s;
    logic [OUT_W-1:0] t;
    logic             m;
    s = p[ACC_W-1 -: OUT_W];
    t = p[ACC_W-2 -: OUT_W];
    m = p[ACC_W-1];
    case (sel)
      MODE_SAW_UP:   shape = s;
      MODE_SAW_DOWN: shape = ~s;
      MODE_TRIANGLE: shape = m ? ~t : t;
      default:       shape = {OUT_W{m}};
    endcase
  endfunction

  // Channel FSM: accumulate, hold the shadow, and swap it in at wrap or sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      acc_q    <= '0;
      act_q    <= '0;
      shadow_q <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (state_q)
        ST_OFF: begin
          if (wr) begin
            act_q   <= wr_cfg;
            acc_q   <= '0;
            state_q <= en ? ST_RUN : ST_OFF;
          end
        end
        ST_RUN: begin
          // A stalled channel (inc==0) never wraps, so take the write at once.
          if (wr && act_q.inc == '0) begin
            act_q   <= wr_cfg;
            acc_q   <= '0;
            state_q <= en ? ST_RUN : ST_OFF;
          end else begin
            if (wr) begin
              shadow_q <= wr_cfg;
              state_q  <= ST_PEND;
            end
            if (sync) begin
              acc_q <= '0;
            end else begin
              acc_q <= step[ACC_W-1:0];
              wrap  <= step[ACC_W];
            end
          end
        end
        ST_PEND: begin
          if (sync || step[ACC_W]) begin
            act_q   <= shadow_q;
            acc_q   <= '0;
            wrap    <= !sync;
            state_q <= shadow_q.en ? ST_RUN : ST_OFF;
          end else begin
            acc_q <= step[ACC_W-1:0];
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  // Registered sample; an idle channel always outputs zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
    end else if (state_q == ST_OFF) begin
      val <= '0;
    end else begin
      val <= shape(act_q.mode, acc_q);
    end
  end

endmodule

// File: rtl/wavegen.sv
// Multi-channel waveform generator: config decode plus NCH channel instances.
module wavegen
  import wavegen_pkg::*;
#(
  parameter int ACC_W = 27,
  parameter int OUT_W = 8,
  parameter int NCH   = 4,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic      clk,
  input logic      rst,
  wavegen_if.slave bus
);

  logic [NCH-1:0]         pend;
  logic [(1<<CH_W)-1:0]   pend_map;

  // Pad the pending flags to the full channel index range so that writes to
  // non-existent channels see ready=1 and are simply dropped.
  always_comb begin
    pend_map          = '0;
    pend_map[NCH-1:0] = pend;
  end

  assign bus.cfg_ready = !pend_map[bus.cfg_ch];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic wr;

    assign wr = bus.cfg_valid && bus.cfg_ready && (bus.cfg_ch == CH_W'(c));

    wavegen_ch #(
      .ACC_W(ACC_W),
      .OUT_W(OUT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .wr   (wr),
      .sync (bus.sync),
      .en   (bus.cfg_en),
      .mode (mode_t'(bus.cfg_mode)),
      .inc  (bus.cfg_inc),
      .pend (pend[c]),
      .wrap (bus.wrap[c]),
      .val  (bus.val[c*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_wavegen.sv
// Scoreboard bench for wavegen: reference model predicts samples per cycle,
// monitor compares them against the DUT.
module tb_wavegen;

  localparam int ACC_W = 8;
  localparam int OUT_W = 4;
  localparam int NCH   = 2;
  localparam int CH_W  = 1;
  localparam int MOD   = 1 << ACC_W;
  localparam int FULL  = (1 << OUT_W) - 1;

  typedef struct packed {
    logic [NCH*OUT_W-1:0] val;
    logic [NCH-1:0]       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  wavegen_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .NCH(NCH), .CH_W(CH_W)) bus ();

  wavegen #(.ACC_W(ACC_W), .OUT_W(OUT_W), .NCH(NCH), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: channel on/off, phase, active and shadow settings.
  bit on[NCH];
  bit waiting[NCH];
  int ph[NCH];
  int cur_inc[NCH];
  int cur_mode[NCH];
  bit sh_en[NCH];
  int sh_mode[NCH];
  int sh_inc[NCH];

  function automatic int sample(int mode, int p);
    int top;
    int x;
    top = p >> (ACC_W - OUT_W);
    x   = p >> (ACC_W - OUT_W - 1);
    case (mode)
      0:       return top;
      1:       return FULL - top;
      2:       return (x <= FULL) ? x : (2 * FULL + 1 - x);
      default: return (p >= MOD / 2) ? FULL : 0;
    endcase
  endfunction

  function automatic bit ref_ready(int ch);
    if (ch >= NCH) return 1'b1;
    return !waiting[ch];
  endfunction

  // Model advance on every clock edge; pushes the outputs expected after it.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    bit   acc_ok;
    int   tgt;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        on[c] = 0; waiting[c] = 0; ph[c] = 0; cur_inc[c] = 0; cur_mode[c] = 0;
        sh_en[c] = 0; sh_mode[c] = 0; sh_inc[c] = 0;
      end
      exp_q.delete();
    end else begin
      e      = '0;
      tgt    = int'(bus.cfg_ch);
      acc_ok = bus.cfg_valid && ref_ready(tgt);
      for (int c = 0; c < NCH; c++) begin
        bit hit;
        int nxt;
        e.val[c*OUT_W +: OUT_W] = on[c] ? OUT_W'(sample(cur_mode[c], ph[c])) : '0;
        hit = acc_ok && (tgt == c);
        nxt = ph[c] + cur_inc[c];
        if (!on[c] || (hit && cur_inc[c] == 0)) begin
          if (hit) begin
            on[c] = bus.cfg_en; cur_mode[c] = int'(bus.cfg_mode);
            cur_inc[c] = int'(bus.cfg_inc); ph[c] = 0;
          end
        end else if (waiting[c] && (bus.sync || nxt >= MOD)) begin
          e.wrap[c] = !bus.sync;
          on[c] = sh_en[c]; cur_mode[c] = sh_mode[c]; cur_inc[c] = sh_inc[c];
          waiting[c] = 0; ph[c] = 0;
        end else begin
          if (bus.sync) ph[c] = 0;
          else begin
            e.wrap[c] = (nxt >= MOD);
            ph[c] = nxt % MOD;
          end
          if (hit) begin
            sh_en[c] = bus.cfg_en; sh_mode[c] = int'(bus.cfg_mode);
            sh_inc[c] = int'(bus.cfg_inc); waiting[c] = 1;
          end
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: samples on the falling edge, ready checked just before the next rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard t=%0t no expected entry", $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.val !== e.val || bus.wrap !== e.wrap) begin
            errors++;
            $display("FAIL sample t=%0t got val=%h wrap=%b exp val=%h wrap=%b",
                     $time, bus.val, bus.wrap, e.val, e.wrap);
          end
        end
        #3;
        if (!rst) begin
          checks++;
          if (bus.cfg_ready !== ref_ready(int'(bus.cfg_ch))) begin
            errors++;
            $display("FAIL cfg_ready t=%0t ch=%0d got %b exp %b",
                     $time, bus.cfg_ch, bus.cfg_ready, ref_ready(int'(bus.cfg_ch)));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, got, want);
    end
  endtask

  // Leaves the bench 1 time unit after a falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic pulse_sync();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
  endtask

  task automatic write(int ch, bit en, int mode, int inc, bit with_sync = 1'b0);
    bus.cfg_ch    = CH_W'(ch);
    bus.cfg_en    = en;
    bus.cfg_mode  = 2'(mode);
    bus.cfg_inc   = ACC_W'(inc);
    bus.cfg_valid = 1'b1;
    bus.sync      = with_sync;
    for (int k = 0; k < 600; k++) begin
      #2;
      if (bus.cfg_ready) begin
        tick();
        bus.cfg_valid = 1'b0;
        bus.sync      = 1'b0;
        return;
      end
      tick();
      bus.sync = 1'b0;
    end
    checks++;
    errors++;
    $display("FAIL cfg_accept ch=%0d timed out waiting for ready", ch);
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int wraps;
    int r;
    int inc;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_en    = 1'b0;
    bus.cfg_mode  = '0;
    bus.cfg_inc   = '0;
    bus.sync      = 1'b0;
    rst           = 1'b1;

    idle(3);
    #2;
    check("reset_val", 32'(bus.val), 32'd0);
    check("reset_wrap", 32'(bus.wrap), 32'd0);
    check("reset_ready", 32'(bus.cfg_ready), 32'd1);
    tick();
    rst = 1'b0;
    idle(2);

    // Saw-up at inc=16: one wrap per 16 clocks.
    write(0, 1, 0, 16);
    wraps = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus.wrap[0]) wraps++;
    end
    check("wrap_period", 32'(wraps), 32'd4);

    // Triangle, then square, each applied at the following wrap.
    write(0, 1, 2, 16);
    idle(40);
    write(0, 1, 3, 16);
    idle(40);

    // Mid-period change to saw-down inc=32; second write stalls on ready.
    write(0, 1, 0, 16);
    idle(21);
    write(0, 1, 1, 32);
    write(0, 1, 1, 32);
    idle(30);

    // Two channels at different rates, realigned by sync.
    write(1, 1, 0, 48);
    idle(7);
    pulse_sync();
    idle(20);

    // inc=0 channel takes new settings immediately; en=0 turns it off at wrap.
    write(1, 1, 0, 0);
    idle(10);
    write(1, 1, 0, 16);
    idle(5);
    write(1, 0, 0, 16);
    idle(25);

    // Write and sync on the same edge.
    write(1, 1, 2, 64, 1'b1);
    write(0, 1, 0, 8, 1'b1);
    idle(3);
    pulse_sync();
    idle(10);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        idle(int'($urandom_range(1, 8)));
      end else if (r < 9) begin
        case ($urandom_range(0, 3))
          0:       inc = 0;
          1:       inc = 1 << $urandom_range(2, 7);
          default: inc = int'($urandom_range(4, 255));
        endcase
        write(int'($urandom_range(0, NCH - 1)), ($urandom_range(0, 4) != 0),
              int'($urandom_range(0, 3)), inc, ($urandom_range(0, 7) == 0));
      end else begin
        pulse_sync();
      end
    end

    // Asynchronous reset while ch0 holds a pending config.
    write(0, 1, 0, 16);
    idle(3);
    write(0, 1, 1, 32);
    bus.cfg_ch = '0;
    check("pend_ready_low", 32'(bus.cfg_ready), 32'd0);
    idle(2);
    #1;
    rst = 1'b1;
    #1;
    check("async_val", 32'(bus.val), 32'd0);
    check("async_wrap", 32'(bus.wrap), 32'd0);
    check("async_ready", 32'(bus.cfg_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    idle(40);
    check("after_reset_val", 32'(bus.val), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
